sequential_divider: RTL and testbench

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/sequential_divider_pkg.sv | 13 +
 rtl/sequential_divider_div_step.sv | 30 +++
 rtl/sequential_divider.sv | 130 +++++++++++++
 tb/tb_sequential_divider.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the default operand width.
package sequential_divider_pkg;

   localparam int DEFAULT_N = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sequential_divider_div_step.sv
// One restoring-division step: shift {rem,q} left, trial-subtract the
// divisor, keep the difference when non-negative, otherwise restore.
module div_step #(
   parameter int N = 32
) (
   input  logic [N:0]   rem,
   input  logic [N-1:0] q,
   input  logic [N-1:0] divisor,
   output logic [N:0]   rem_next,
   output logic [N-1:0] q_next
);

   logic [N+1:0] shifted;
   logic [N+1:0] diff;

   // The partial remainder is always below the divisor, so the shifted value
   // fits in N+1 bits and bit N+1 of the difference is a reliable sign.
   always_comb begin
      shifted  = {rem, q[N-1]};
      diff     = shifted - {2'b00, divisor};
      if (diff[N+1]) begin
         rem_next = shifted[N:0];
         q_next   = {q[N-2:0], 1'b0};
      end else begin
         rem_next = diff[N:0];
         q_next   = {q[N-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/sequential_divider.sv
// Sequential restoring divider, one quotient bit per CALC cycle.
// Build option: SEQUENTIAL_DIVIDER_SIGNED_EN selects two's-complement
// operands (truncating division); default build is unsigned.
module sequential_divider
   import sequential_divider_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero,
   output logic         overflow
);

   localparam int CW = $clog2(N + 1);

   state_t        state, state_nxt;
   logic [N:0]    rem_r, rem_nxt;
   logic [N-1:0]  q_r, q_nxt, dvs_r;
   logic [CW-1:0] cnt;
   logic [N-1:0]  dvd_mag, dvs_mag, q_res, r_res;
   logic          zero, last;

   assign zero = (divisor == '0);
   assign last = (cnt == CW'(N));
   assign busy = (state != IDLE);
   assign done = (state == DONE);

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
   logic neg_q, neg_r, ovf_r;

   assign dvd_mag  = dividend[N-1] ? -dividend : dividend;
   assign dvs_mag  = divisor[N-1]  ? -divisor  : divisor;
   assign q_res    = neg_q ? -q_r : q_r;
   assign r_res    = neg_r ? -rem_r[N-1:0] : rem_r[N-1:0];
   assign overflow = ovf_r;

   // Sign bookkeeping captured with the operands; -2^(N-1)/-1 wraps back to
   // -2^(N-1) through the normal negate path and is only flagged here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         ovf_r <= 1'b0;
      end else if (state == IDLE && start) begin
         neg_q <= dividend[N-1] ^ divisor[N-1];
         neg_r <= dividend[N-1];
         ovf_r <= (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
      end
   end
`else
   assign dvd_mag  = dividend;
   assign dvs_mag  = divisor;
   assign q_res    = q_r;
   assign r_res    = rem_r[N-1:0];
   assign overflow = 1'b0;
`endif

   div_step #(.N(N)) u_step (
      .rem      (rem_r),
      .q        (q_r),
      .divisor  (dvs_r),
      .rem_next (rem_nxt),
      .q_next   (q_nxt)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: a zero divisor skips straight to DONE; CALC spends one
   // extra cycle at count==N to load the result registers.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = zero ? DONE : CALC;
         CALC:    if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, and result load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem_r       <= '0;
         q_r         <= '0;
         dvs_r       <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               if (zero) begin
                  quotient    <= '1;
                  remainder   <= dividend;
                  div_by_zero <= 1'b1;
               end else begin
                  q_r         <= dvd_mag;
                  dvs_r       <= dvs_mag;
                  rem_r       <= '0;
                  cnt         <= '0;
                  div_by_zero <= 1'b0;
               end
            end
            CALC: if (!last) begin
               rem_r <= rem_nxt;
               q_r   <= q_nxt;
               cnt   <= cnt + 1'b1;
            end else begin
               quotient  <= q_res;
               remainder <= r_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed self-checking bench for sequential_divider (N=32).
module tb_sequential_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] dividend, divisor;
   logic [31:0] quotient, remainder;
   logic        busy, done, div_by_zero, overflow;

   int errors = 0;
   int checks = 0;

   sequential_divider #(.N(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Issue one operation and wait for done; lat counts edges after the
   // accepting edge (0 means done is already high right after it).
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic check_result(input string name, input int lat, input int exp_lat,
                               input logic [31:0] eq, input logic [31:0] er,
                               input logic edz, input logic eov);
      checks++;
      if (lat !== exp_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
      checks++;
      if (quotient !== eq) begin errors++; $display("FAIL %s quotient: got %h want %h", name, quotient, eq); end
      checks++;
      if (remainder !== er) begin errors++; $display("FAIL %s remainder: got %h want %h", name, remainder, er); end
      checks++;
      if (div_by_zero !== edz) begin errors++; $display("FAIL %s div_by_zero: got %b want %b", name, div_by_zero, edz); end
      checks++;
      if (overflow !== eov) begin errors++; $display("FAIL %s overflow: got %b want %b", name, overflow, eov); end
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      #12;
      checks++;
      if ({quotient, remainder} !== 64'd0) begin errors++; $display("FAIL reset_data: got %h/%h want 0/0", quotient, remainder); end
      checks++;
      if ({busy, done, div_by_zero, overflow} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, div_by_zero, overflow}); end
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_basic;
      int lat;
      run_op(32'd100, 32'd7, lat);
      check_result("100/7", lat, 33, 32'd14, 32'd2, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_done: got %b want 1", busy); end
      @(posedge clk); #1;
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL done_pulse: got done,busy=%b want 00", {done, busy}); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({quotient, remainder} !== {32'd14, 32'd2}) begin errors++; $display("FAIL hold: got %h/%h want 14/2", quotient, remainder); end
   endtask

   task automatic test_vectors;
      int lat;
      run_op(32'hFFFF_FFFF, 32'd1, lat);
      check_result("max/1", lat, 33, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      run_op(32'd5, 32'd9, lat);
      check_result("5/9", lat, 33, 32'd0, 32'd5, 1'b0, 1'b0);
      @(posedge clk); #1;
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      check_result("max/max", lat, 33, 32'd1, 32'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic test_div_zero;
      int lat;
      run_op(32'd42, 32'd0, lat);
      check_result("42/0", lat, 0, 32'hFFFF_FFFF, 32'd42, 1'b1, 1'b0);
      @(posedge clk); #1;
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL dz_return: got done,busy=%b want 00", {done, busy}); end
      // A following normal operation must clear the flag.
      run_op(32'd9, 32'd3, lat);
      check_result("9/3", lat, 33, 32'd3, 32'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic test_ignore_start;
      int lat;
      dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 10) begin start = 1'b1; dividend = 32'd50; divisor = 32'd5; end
         else if (lat == 11) start = 1'b0;
      end
      check_result("ignore_start", lat, 33, 32'd14, 32'd2, 1'b0, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int lat;
      bit seen;
      dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      checks++;
      if ({quotient, remainder} !== 64'd0) begin errors++; $display("FAIL midreset_data: got %h/%h want 0/0", quotient, remainder); end
      checks++;
      if ({busy, done, div_by_zero, overflow} !== 4'b0) begin errors++; $display("FAIL midreset_flags: got %b want 0000", {busy, done, div_by_zero, overflow}); end
      @(posedge clk); #1;
      reset = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got activity=%b want 0", seen); end
      // Start asserted together with reset release is taken on the next edge.
      reset = 1'b0;
      #2 reset = 1'b1;
      run_op(32'd5, 32'd9, lat);
      check_result("after_reset", lat, 33, 32'd0, 32'd5, 1'b0, 1'b0);
      @(posedge clk); #1;
   endtask

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
   task automatic test_signed;
      int lat;
      run_op(-32'sd7, 32'd2, lat);
      check_result("-7/2", lat, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
      @(posedge clk); #1;
      run_op(32'd7, -32'sd2, lat);
      check_result("7/-2", lat, 33, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
      @(posedge clk); #1;
      run_op(32'h8000_0000, 32'hFFFF_FFFF, lat);
      check_result("min/-1", lat, 33, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_vectors;
      test_div_zero;
      test_ignore_start;
      test_reset_mid;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
      test_signed;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
